// File: rtl/pll_seq_pkg.sv
// Shared state type and default timing for the PLL lock / core reset sequencer.
// Optional feature macro: PLL_AUTO_RELOCK_EN (adds the RELOCK state).
package pll_seq_pkg;

    localparam int DEF_LOCK_STABLE_CYCLES = 4096;
    localparam int DEF_RESET_HOLD_CYCLES  = 256;
    localparam int DEF_CE_DIV             = 8;   // 48 MHz -> 6 MHz pixel enable
    localparam int DEF_CE_PHASE           = 2;   // quarter period at divide-by-8
    localparam int DEF_RELOCK_PULSE       = 16;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        STABLE    = 3'd1,
        HOLD      = 3'd2,
        RUN       = 3'd3
`ifdef PLL_AUTO_RELOCK_EN
        ,
        RELOCK    = 3'd4
`endif
    } seq_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// N-stage single-bit synchronizer with asynchronous active-low reset.
// Reused for any asynchronous status flag entering the core clock domain.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] stage_reg;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        if (gi == 0) begin : g_first
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) stage_reg[gi] <= 1'b0;
                else          stage_reg[gi] <= d;
            end
        end else begin : g_chain
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) stage_reg[gi] <= 1'b0;
                else          stage_reg[gi] <= stage_reg[gi-1];
            end
        end
    end

    assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/pll_lock_reset_seq.sv
// Holds the game core in reset until PLL lock is stable, then runs the 6 MHz
// pixel enables. Optional feature macro: PLL_AUTO_RELOCK_EN (pulse pll_rst on lock loss).
module pll_lock_reset_seq
    import pll_seq_pkg::*;
#(
    parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
    parameter int RESET_HOLD_CYCLES  = DEF_RESET_HOLD_CYCLES,
    parameter int CE_DIV             = DEF_CE_DIV,
    parameter int CE_PHASE           = DEF_CE_PHASE,
    parameter int RELOCK_PULSE       = DEF_RELOCK_PULSE
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pll_locked,
    output logic       core_reset_n,
    output logic       ce_pix,
    output logic       ce_pix_q,
    output logic       pll_rst,
    output logic [7:0] lock_lost_cnt
);

    localparam int CNT_MAX = max3(LOCK_STABLE_CYCLES, RESET_HOLD_CYCLES, RELOCK_PULSE);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int DIV_W   = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD_CYCLES - 1);
`ifdef PLL_AUTO_RELOCK_EN
    localparam logic [CNT_W-1:0] RELOCK_LAST = CNT_W'(RELOCK_PULSE - 1);
`endif
    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(CE_DIV - 1);
    localparam logic [DIV_W-1:0] PHASE_TAP   = DIV_W'(CE_PHASE - 1);

    if (CE_PHASE < 1 || CE_PHASE > CE_DIV - 1) begin : g_bad_phase
        $error("pll_lock_reset_seq: CE_PHASE must lie in 1..CE_DIV-1");
    end

    logic             lk;
    seq_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [DIV_W-1:0] div_reg, div_next;
    logic             core_reset_n_reg, core_reset_n_next;
    logic             ce_pix_reg, ce_pix_next;
    logic             ce_pix_q_reg, ce_pix_q_next;
    logic             pll_rst_reg, pll_rst_next;
    logic [7:0]       lost_reg, lost_next;
    logic             active_now, active_next;

    sync_ff #(
        .STAGES (2)
    ) u_lock_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (pll_locked),
        .q       (lk)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            WAIT_LOCK: if (lk) state_next = STABLE;
            STABLE: begin
                if (!lk)                         state_next = WAIT_LOCK;
                else if (cnt_reg == STABLE_LAST) state_next = HOLD;
            end
            // A drop on the last hold cycle wins over the move to RUN.
            HOLD: begin
                if (!lk)                       state_next = WAIT_LOCK;
                else if (cnt_reg == HOLD_LAST) state_next = RUN;
            end
            RUN: begin
`ifdef PLL_AUTO_RELOCK_EN
                if (!lk) state_next = RELOCK;
`else
                if (!lk) state_next = WAIT_LOCK;
`endif
            end
`ifdef PLL_AUTO_RELOCK_EN
            RELOCK: if (cnt_reg == RELOCK_LAST) state_next = WAIT_LOCK;
`endif
            default: state_next = WAIT_LOCK;
        endcase

        cnt_next = '0;
        if (state_next == state_reg) begin
            case (state_reg)
                STABLE, HOLD: cnt_next = cnt_reg + CNT_W'(1);
`ifdef PLL_AUTO_RELOCK_EN
                RELOCK:       cnt_next = cnt_reg + CNT_W'(1);
`endif
                default:      cnt_next = '0;
            endcase
        end

        // Enables are produced from the current divider value, so they lag it by one edge.
        active_now  = (state_reg == HOLD) || (state_reg == RUN);
        active_next = (state_next == HOLD) || (state_next == RUN);
        div_next    = '0;
        if (active_now && active_next) begin
            div_next = (div_reg == DIV_LAST) ? '0 : div_reg + DIV_W'(1);
        end
        ce_pix_next   = active_now && active_next && (div_reg == DIV_LAST);
        ce_pix_q_next = active_now && active_next && (div_reg == PHASE_TAP);

        core_reset_n_next = (state_reg == RUN) && (state_next == RUN);
`ifdef PLL_AUTO_RELOCK_EN
        pll_rst_next = (state_next == RELOCK);
`else
        pll_rst_next = 1'b0;
`endif

        lost_next = lost_reg;
        if ((state_reg == RUN) && !lk && (lost_reg != 8'hFF)) begin
            lost_next = lost_reg + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg        <= WAIT_LOCK;
            cnt_reg          <= '0;
            div_reg          <= '0;
            core_reset_n_reg <= 1'b0;
            ce_pix_reg       <= 1'b0;
            ce_pix_q_reg     <= 1'b0;
            pll_rst_reg      <= 1'b0;
            lost_reg         <= 8'd0;
        end else begin
            state_reg        <= state_next;
            cnt_reg          <= cnt_next;
            div_reg          <= div_next;
            core_reset_n_reg <= core_reset_n_next;
            ce_pix_reg       <= ce_pix_next;
            ce_pix_q_reg     <= ce_pix_q_next;
            pll_rst_reg      <= pll_rst_next;
            lost_reg         <= lost_next;
        end
    end

    assign core_reset_n  = core_reset_n_reg;
    assign ce_pix        = ce_pix_reg;
    assign ce_pix_q      = ce_pix_q_reg;
    assign pll_rst       = pll_rst_reg;
    assign lock_lost_cnt = lost_reg;

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Self-checking bench for pll_lock_reset_seq: vector table for the release sequence,
// a cycle-stamped scoreboard for lock loss, glitch, reset and saturation cases.
module tb_pll_lock_reset_seq;

    localparam int LSC = 16;
    localparam int RHC = 8;
    localparam int DIV = 8;
    localparam int PH  = 2;
    localparam int RP  = 16;
`ifdef PLL_AUTO_RELOCK_EN
    localparam int RELOCK_ON = 1;
`else
    localparam int RELOCK_ON = 0;
`endif

    localparam int S_CRN  = 0;
    localparam int S_CE   = 1;
    localparam int S_CEQ  = 2;
    localparam int S_PRST = 3;
    localparam int S_LOST = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       pll_locked;
    logic       core_reset_n;
    logic       ce_pix;
    logic       ce_pix_q;
    logic       pll_rst;
    logic [7:0] lock_lost_cnt;

    pll_lock_reset_seq #(
        .LOCK_STABLE_CYCLES (LSC),
        .RESET_HOLD_CYCLES  (RHC),
        .CE_DIV             (DIV),
        .CE_PHASE           (PH),
        .RELOCK_PULSE       (RP)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .pll_locked    (pll_locked),
        .core_reset_n  (core_reset_n),
        .ce_pix        (ce_pix),
        .ce_pix_q      (ce_pix_q),
        .pll_rst       (pll_rst),
        .lock_lost_cnt (lock_lost_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        string name;
        int    at;
        int    sig;
        int    val;
    } exp_t;

    typedef struct {
        int   at;
        logic lock;
        logic crn;
        logic ce;
        logic ceq;
    } vec_t;

    exp_t sb[$];
    exp_t e;
    vec_t vecs [12];

    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got == want) begin
            n_pass++;
            $display("ok   %s @%0d got %0d", name, cyc, got);
        end else begin
            $display("FAIL %s @%0d: got %0d, expected %0d", name, cyc, got, want);
        end
    endtask

    task automatic expect_at(input string name, input int at, input int sig, input int val);
        exp_t x;
        x.name = name;
        x.at   = at;
        x.sig  = sig;
        x.val  = val;
        sb.push_back(x);
    endtask

    function automatic int sample(input int sig);
        case (sig)
            S_CRN:   return int'(core_reset_n);
            S_CE:    return int'(ce_pix);
            S_CEQ:   return int'(ce_pix_q);
            S_PRST:  return int'(pll_rst);
            default: return int'(lock_lost_cnt);
        endcase
    endfunction

    // Leaves the caller 1 time unit after posedge number n.
    task automatic wait_until(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            e = sb.pop_front();
            if (e.at < cyc) check({e.name, " missed"}, cyc, e.at);
            else            check(e.name, sample(e.sig), e.val);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: run exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int b, d, b2, r0, r1, p, b3, g, lv;

        vecs = '{
            '{0,  1'b1, 1'b0, 1'b0, 1'b0},
            '{1,  1'b1, 1'b0, 1'b0, 1'b0},
            '{20, 1'b1, 1'b0, 1'b0, 1'b0},
            '{21, 1'b1, 1'b0, 1'b0, 1'b1},
            '{22, 1'b1, 1'b0, 1'b0, 1'b0},
            '{26, 1'b1, 1'b0, 1'b0, 1'b0},
            '{27, 1'b1, 1'b0, 1'b1, 1'b0},
            '{28, 1'b1, 1'b1, 1'b0, 1'b0},
            '{29, 1'b1, 1'b1, 1'b0, 1'b1},
            '{35, 1'b1, 1'b1, 1'b1, 1'b0},
            '{36, 1'b1, 1'b1, 1'b0, 1'b0},
            '{37, 1'b1, 1'b1, 1'b0, 1'b1}
        };

        reset_n    = 1'b0;
        pll_locked = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset core_reset_n", int'(core_reset_n), 0);
        check("reset ce_pix", int'(ce_pix), 0);
        check("reset ce_pix_q", int'(ce_pix_q), 0);
        check("reset pll_rst", int'(pll_rst), 0);
        check("reset lock_lost_cnt", int'(lock_lost_cnt), 0);
        reset_n = 1'b1;

        // Lock rises and holds: release at +28, enables from +21/+27.
        b = cyc + 2;
        foreach (vecs[i]) begin
            wait_until(b + vecs[i].at);
            pll_locked = vecs[i].lock;
            expect_at($sformatf("rise+%0d core_reset_n", vecs[i].at), b + vecs[i].at, S_CRN, int'(vecs[i].crn));
            expect_at($sformatf("rise+%0d ce_pix", vecs[i].at), b + vecs[i].at, S_CE, int'(vecs[i].ce));
            expect_at($sformatf("rise+%0d ce_pix_q", vecs[i].at), b + vecs[i].at, S_CEQ, int'(vecs[i].ceq));
            expect_at($sformatf("rise+%0d pll_rst", vecs[i].at), b + vecs[i].at, S_PRST, 0);
            expect_at($sformatf("rise+%0d lock_lost_cnt", vecs[i].at), b + vecs[i].at, S_LOST, 0);
        end

        // Lock loss in RUN; lk falls two edges after the pin.
        d = b + 40;
        wait_until(d);
        pll_locked = 1'b0;
        expect_at("drop core_reset_n before", d + 2, S_CRN, 1);
        expect_at("drop lost before", d + 2, S_LOST, 0);
        for (int k = 3; k <= 11; k++) begin
            if (k == 3) begin
                expect_at("drop core_reset_n low", d + 3, S_CRN, 0);
                expect_at("drop lost count", d + 3, S_LOST, 1);
                expect_at("drop pll_rst first", d + 3, S_PRST, RELOCK_ON);
            end
            expect_at($sformatf("drop+%0d ce_pix off", k), d + k, S_CE, 0);
            expect_at($sformatf("drop+%0d ce_pix_q off", k), d + k, S_CEQ, 0);
        end
        expect_at("drop pll_rst last", d + 18, S_PRST, RELOCK_ON);
        expect_at("drop pll_rst ended", d + 19, S_PRST, 0);

        b2 = d + 20;
        wait_until(b2);
        pll_locked = 1'b1;
        expect_at("relock core_reset_n +27", b2 + 27, S_CRN, 0);
        expect_at("relock core_reset_n +28", b2 + 28, S_CRN, 1);
        expect_at("relock lost kept", b2 + 28, S_LOST, 1);
        expect_at("relock pll_rst idle", b2 + 28, S_PRST, 0);

        // Asynchronous reset in RUN, checked between clock edges.
        r0 = b2 + 40;
        wait_until(r0);
        #1;
        check("pre-reset core_reset_n", int'(core_reset_n), 1);
        check("pre-reset lock_lost_cnt", int'(lock_lost_cnt), 1);
        reset_n = 1'b0;
        #1;
        check("async reset core_reset_n", int'(core_reset_n), 0);
        check("async reset ce_pix", int'(ce_pix), 0);
        check("async reset ce_pix_q", int'(ce_pix_q), 0);
        check("async reset pll_rst", int'(pll_rst), 0);
        check("async reset lock_lost_cnt", int'(lock_lost_cnt), 0);
        r1 = r0 + 3;
        wait_until(r1);
        check("held reset core_reset_n", int'(core_reset_n), 0);
        reset_n = 1'b1;
        expect_at("post-reset ce_pix_q +20", r1 + 20, S_CEQ, 0);
        expect_at("post-reset ce_pix_q +21", r1 + 21, S_CEQ, 1);
        expect_at("post-reset core_reset_n +27", r1 + 27, S_CRN, 0);
        expect_at("post-reset ce_pix +27", r1 + 27, S_CE, 1);
        expect_at("post-reset core_reset_n +28", r1 + 28, S_CRN, 1);

        // Three-cycle lock drop in mid-STABLE restarts the whole window.
        p = r1 + 35;
        wait_until(p);
        pll_locked = 1'b0;
        reset_n    = 1'b0;
        wait_until(p + 2);
        reset_n = 1'b1;
        b3 = p + 5;
        wait_until(b3);
        pll_locked = 1'b1;
        g = b3 + 10;
        wait_until(g);
        pll_locked = 1'b0;
        wait_until(g + 3);
        pll_locked = 1'b1;
        expect_at("glitch no early release", b3 + 28, S_CRN, 0);
        expect_at("glitch ce_pix_q +20", g + 23, S_CEQ, 0);
        expect_at("glitch ce_pix_q +21", g + 24, S_CEQ, 1);
        expect_at("glitch core_reset_n +27", g + 30, S_CRN, 0);
        expect_at("glitch core_reset_n +28", g + 31, S_CRN, 1);
        expect_at("glitch lost untouched", g + 31, S_LOST, 0);

        // 300 losses from RUN: the counter must stick at 255.
        d = g + 40;
        for (int i = 1; i <= 300; i++) begin
            wait_until(d);
            pll_locked = 1'b0;
            if (i == 1 || i == 254 || i == 255 || i == 256 || i == 300) begin
                lv = (i - 1 > 255) ? 255 : i - 1;
                expect_at($sformatf("loss %0d lost before", i), d + 2, S_LOST, lv);
                lv = (i > 255) ? 255 : i;
                expect_at($sformatf("loss %0d lost after", i), d + 3, S_LOST, lv);
                expect_at($sformatf("loss %0d core_reset_n", i), d + 3, S_CRN, 0);
            end
            wait_until(d + 20);
            pll_locked = 1'b1;
            d = d + 52;
        end

        wait_until(d + 10);
        check("scoreboard drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
